// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: pairs bytes from the camera bus into 16-bit pixels
// and writes them to a linear frame buffer at row*H_PIX + col.
module ov7670_capture #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240,
  parameter int ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              frame_start,
  output logic              frame_done,
  output logic              line_ovf,
  output logic              frame_ovf,
  output logic              odd_err,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SYNC    = 2'd1;
  localparam logic [1:0] S_VBLANK  = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [ADDR_W-1:0] L_H = ADDR_W'(H_PIX);
  localparam logic [ADDR_W-1:0] L_V = ADDR_W'(V_LINES);

  logic [1:0]        r_state;
  logic              r_href_prev;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_line_base;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [15:0]       r_wdata;
  logic              r_frame_start;
  logic              r_frame_done;
  logic              r_line_ovf;
  logic              r_frame_ovf;
  logic              r_odd_err;

  logic w_fall;
  logic w_col_ok;
  logic w_row_ok;

  assign w_fall   = r_href_prev & ~href;
  assign w_col_ok = (r_col < L_H);
  assign w_row_ok = (r_row < L_V);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_href_prev   <= 1'b0;
      r_phase       <= 1'b0;
      r_hi          <= 8'd0;
      r_col         <= '0;
      r_row         <= '0;
      r_line_base   <= '0;
      r_we          <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= 16'd0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_line_ovf    <= 1'b0;
      r_frame_ovf   <= 1'b0;
      r_odd_err     <= 1'b0;
    end else begin
      r_we          <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_href_prev   <= href;
      case (r_state)
        S_IDLE: if (enable) r_state <= S_SYNC;
        // Waiting for blanking first keeps a frame that is already running from being captured.
        S_SYNC: if (vsync) r_state <= S_VBLANK;
        S_VBLANK: begin
          if (!vsync) begin
            r_state       <= S_CAPTURE;
            r_frame_start <= 1'b1;
            r_row         <= '0;
            r_col         <= '0;
            r_line_base   <= '0;
            r_phase       <= 1'b0;
            r_line_ovf    <= 1'b0;
            r_frame_ovf   <= 1'b0;
            r_odd_err     <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (href) begin
            if (!r_phase) begin
              r_hi    <= d;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (w_col_ok && w_row_ok) begin
                r_we    <= 1'b1;
                r_waddr <= r_line_base + r_col;
                r_wdata <= {r_hi, d};
              end
              if (!w_col_ok) r_line_ovf <= 1'b1;
              if (!w_row_ok) r_frame_ovf <= 1'b1;
              if (w_col_ok) r_col <= r_col + ADDR_W'(1);
            end
          end else if (w_fall) begin
            if (r_phase) begin
              r_odd_err <= 1'b1;
              r_phase   <= 1'b0;
            end
            // Row and line_base stop once the frame is full, so the base never wraps.
            if (r_col != '0 && w_row_ok) begin
              r_row       <= r_row + ADDR_W'(1);
              r_line_base <= r_line_base + L_H;
            end
            r_col <= '0;
          end
          if (vsync) begin
            r_frame_done <= 1'b1;
            r_state      <= enable ? S_VBLANK : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign we          = r_we;
  assign waddr       = r_waddr;
  assign wdata       = r_wdata;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign line_ovf    = r_line_ovf;
  assign frame_ovf   = r_frame_ovf;
  assign odd_err     = r_odd_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: frames are built as byte lists, a frame-level model
// predicts the pixel writes and flags, and a scoreboard checks every write.
module tb_ov7670_capture;

  localparam int H_PIX   = 4;
  localparam int V_LINES = 2;
  localparam int ADDR_W  = 8;
  localparam int W       = ADDR_W + 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              vsync = 1'b0;
  logic              href = 1'b0;
  logic [7:0]        d = 8'd0;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              frame_start;
  logic              frame_done;
  logic              line_ovf;
  logic              frame_ovf;
  logic              odd_err;
  logic [1:0]        o_dbg_state;

  ov7670_capture #(.H_PIX(H_PIX), .V_LINES(V_LINES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .href(href), .d(d),
    .we(we), .waddr(waddr), .wdata(wdata), .frame_start(frame_start),
    .frame_done(frame_done), .line_ovf(line_ovf), .frame_ovf(frame_ovf),
    .odd_err(odd_err), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int fs_count = 0, fd_count = 0, exp_fs = 0, exp_fd = 0;
  logic exp_lovf, exp_fovf, exp_odd;
  logic [7:0] line_bytes[$];
  int line_len[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_start) fs_count++;
    if (frame_done) fd_count++;
    if (we) begin
      if (exp_q.size() == 0) check("spurious_we", 32'(we), 32'd0);
      else check("write", 32'({waddr, wdata}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- reference model ----------------
  // Each line holds len/2 pixels; pixel p of row r goes to r*H_PIX+p while in range.
  task automatic model_frame();
    int row = 0;
    int pos = 0;
    exp_lovf = 1'b0;
    exp_fovf = 1'b0;
    exp_odd  = 1'b0;
    foreach (line_len[li]) begin
      int npix;
      npix = line_len[li] / 2;
      for (int p = 0; p < npix; p++) begin
        if (p >= H_PIX) exp_lovf = 1'b1;
        if (row >= V_LINES) exp_fovf = 1'b1;
        if (p < H_PIX && row < V_LINES)
          exp_q.push_back({ADDR_W'(row * H_PIX + p), line_bytes[pos + 2*p], line_bytes[pos + 2*p + 1]});
      end
      if (line_len[li] % 2 != 0) exp_odd = 1'b1;
      if (npix > 0 && row < V_LINES) row++;
      pos += line_len[li];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_frame();
    line_len.delete();
    line_bytes.delete();
  endtask

  task automatic add_line(input int len, input bit rnd);
    line_len.push_back(len);
    for (int i = 0; i < len; i++)
      line_bytes.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(8'h12 + 8'h22 * i));
  endtask

  task automatic drive_line(input int pos, input int len, input bit close);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      href = 1'b1;
      d = line_bytes[pos + i];
    end
    @(negedge clk);
    href = 1'b0;
    d = 8'($urandom_range(0, 255));
    if (close) vsync = 1'b1;
    else repeat (2) @(negedge clk);
  endtask

  task automatic start_frame(input bit cap);
    repeat (4) begin
      @(negedge clk);
      vsync = 1'b1;
      href = 1'b0;
    end
    @(negedge clk);
    vsync = 1'b0;
    @(posedge clk);
    #1;
    check("frame_start", 32'(frame_start), 32'(cap));
    if (cap) check("flags_cleared", 32'({line_ovf, frame_ovf, odd_err}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      href = 1'b0;
    end
  endtask

  task automatic run_frame(input bit cap, input bit drop_en, input bit close_on_fall);
    int pos = 0;
    if (cap) begin
      model_frame();
      exp_fs++;
      exp_fd++;
    end
    start_frame(cap);
    foreach (line_len[li]) begin
      if (drop_en && li == 1) enable = 1'b0;
      drive_line(pos, line_len[li], close_on_fall && li == line_len.size() - 1);
      pos += line_len[li];
    end
    if (!close_on_fall) begin
      @(negedge clk);
      vsync = 1'b1;
    end
    @(posedge clk);
    #1;
    check("frame_done", 32'(frame_done), 32'(cap));
    @(negedge clk);
    check("state_after_frame", 32'(o_dbg_state), enable ? 32'd2 : 32'd0);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    if (cap) begin
      check("line_ovf", 32'(line_ovf), 32'(exp_lovf));
      check("frame_ovf", 32'(frame_ovf), 32'(exp_fovf));
      check("odd_err", 32'(odd_err), 32'(exp_odd));
    end
  endtask

  // Lines sent while the block must not capture; any write is caught by the scoreboard.
  task automatic drive_uncaptured_lines();
    int pos = 0;
    foreach (line_len[li]) begin
      drive_line(pos, line_len[li], 1'b0);
      pos += line_len[li];
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_pulses", 32'({frame_start, frame_done}), 32'd0);
    check("rst_flags", 32'({line_ovf, frame_ovf, odd_err}), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Enable while a frame is already active: nothing may be written.
    enable = 1'b1;
    clear_frame();
    add_line(8, 1'b1);
    add_line(8, 1'b1);
    drive_uncaptured_lines();

    // Basic frame: 0x12,0x34,... on two lines.
    clear_frame();
    add_line(8, 1'b0);
    add_line(8, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);

    // Long line 0.
    clear_frame();
    add_line(12, 1'b0);
    add_line(8, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0);

    // Odd line plus an extra line beyond V_LINES.
    clear_frame();
    add_line(7, 1'b1);
    add_line(8, 1'b1);
    add_line(8, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0);

    // Odd last line whose href fall coincides with vsync rising.
    clear_frame();
    add_line(8, 1'b1);
    add_line(7, 1'b1);
    run_frame(1'b1, 1'b0, 1'b1);

    for (int f = 0; f < 8; f++) begin
      int nl;
      nl = $urandom_range(1, 3);
      clear_frame();
      for (int l = 0; l < nl; l++) add_line($urandom_range(0, 11), 1'b1);
      run_frame(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end

    // Enable drops mid-frame: frame completes, then nothing more is captured.
    clear_frame();
    add_line(8, 1'b1);
    add_line(8, 1'b1);
    add_line(6, 1'b1);
    run_frame(1'b1, 1'b1, 1'b0);
    clear_frame();
    add_line(8, 1'b1);
    add_line(8, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);
    check("fs_count_after_drop", 32'(fs_count), 32'(exp_fs));

    // Reset in the middle of line 1 after 3 pixels.
    enable = 1'b1;
    clear_frame();
    add_line(12, 1'b1);
    add_line(6, 1'b1);
    model_frame();
    exp_fs++;
    start_frame(1'b1);
    drive_line(0, 12, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      href = 1'b1;
      d = line_bytes[12 + i];
    end
    @(negedge clk);
    #2;
    check("line_ovf_before_reset", 32'(line_ovf), 32'd1);
    reset = 1'b0;
    #1;
    check("reset_we", 32'(we), 32'd0);
    check("reset_waddr", 32'(waddr), 32'd0);
    check("reset_wdata", 32'(wdata), 32'd0);
    check("reset_flags", 32'({line_ovf, frame_ovf, odd_err}), 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'd0);
    check("reset_writes_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    href = 1'b0;
    vsync = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_frame();
    add_line(8, 1'b1);
    add_line(8, 1'b1);
    drive_uncaptured_lines();
    clear_frame();
    add_line(8, 1'b1);
    add_line(8, 1'b1);
    run_frame(1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("frame_start_count", 32'(fs_count), 32'(exp_fs));
    check("frame_done_count", 32'(fd_count), 32'(exp_fd));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Pixel capture stage fed by the OV7670 after the SCCB configuration sequence selects RGB565 output. The block samples the camera's parallel bus (VSYNC, HREF, D[7:0]) on the pixel clock and assembles byte pairs into 16-bit pixels. It issues one write per pixel into the downstream frame buffer, with a linear address of row·H_PIX + col. Frame and line framing errors are reported as sticky flags.

## Interface
- H_PIX, 320: pixels per line written to the buffer.
- V_LINES, 240: lines per frame written to the buffer.
- ADDR_W, 17: write address width; must satisfy 2^ADDR_W ≥ H_PIX·V_LINES.
- clk  in  1  camera PCLK; all logic is on the rising edge; this is the only clock.
- reset  in  1  asynchronous, active-low reset; all state clears while low.
- enable  in  1  capture request; sampled only at frame boundaries.
- vsync  in  1  camera VSYNC; high = vertical blanking.
- href  in  1  camera HREF; high = valid line bytes.
- d  in  8  camera data byte.
- we  out  1  one-cycle pixel write strobe.
- waddr  out  ADDR_W  pixel address.
- wdata  out  16  RGB565 pixel as {first byte, second byte}.
- frame_start  out  1  one-cycle pulse when capture of a frame begins.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- line_ovf  out  1  sticky flag: a line carried more than H_PIX pixels.
- frame_ovf  out  1  sticky flag: a frame carried more than V_LINES lines.
- odd_err  out  1  sticky flag: a line ended on an unpaired byte.

## Operation
- Reset values: state IDLE; we, frame_start, frame_done and all three flags 0; waddr 0; wdata 0; col, row, line_base and byte phase 0; href_prev 0.
- States and transitions:
  - IDLE: if enable = 1, go to SYNC.
  - SYNC: wait for vsync = 1, then go to VBLANK. This step guarantees a partial frame is never written.
  - VBLANK: wait for vsync = 0. On that edge:
    - go to CAPTURE;
    - pulse frame_start;
    - clear row, col, line_base, phase and all flags.
  - CAPTURE: on vsync = 1:
    - pulse frame_done;
    - go to VBLANK if enable = 1, else go to IDLE.
- Byte pairing (CAPTURE, href = 1):
  - phase 0: latch d as the high byte; set phase to 1.
  - phase 1: form the pixel {high byte, d}; set phase to 0.
    - If col < H_PIX and row < V_LINES: write the pixel with waddr = line_base + col.
    - Increment col, saturating at H_PIX.
- Pixel range checks:
  - col ≥ H_PIX: no write; set line_ovf.
  - row ≥ V_LINES: no write; set frame_ovf.
- End of line: detected as href falling (href_prev = 1, href = 0) while in CAPTURE.
  - If phase = 1: discard the held byte, set odd_err, clear phase.
  - If col > 0: increment row (saturating at V_LINES) and add H_PIX to line_base.
  - Always clear col.
  - A short line (col < H_PIX) leaves its unwritten tail unchanged; the next line still starts at the next multiple of H_PIX.
- href pulses while vsync = 1, or in IDLE/SYNC/VBLANK, are ignored.
- Dropping enable mid-frame finishes the current frame, then the block goes to IDLE.
- Address arithmetic: line_base, col and waddr are unsigned ADDR_W-bit values. The maximum address is H_PIX·V_LINES − 1; no wrap occurs because of the row and column guards.

## Timing
- Latency: we is asserted for one cycle, immediately after the rising edge that sampled the second byte. waddr and wdata are valid during that same cycle.
- Maximum write rate: one write every 2 cycles. There is no backpressure; the downstream buffer must accept every we.
- frame_start is asserted in the cycle after the edge where vsync is first seen low in VBLANK.
- frame_done is asserted in the cycle after the edge where vsync is first seen high in CAPTURE.
- Simultaneous events:
  - vsync rising in the same cycle as href falling: the end-of-line update applies, then the frame closes.
  - A write in progress on that edge still completes.
- Reset asserted mid-line: all outputs clear immediately (asynchronously). After release the block passes through IDLE → SYNC → VBLANK, so no write occurs before the next full vsync high→low transition.

## Test plan
- Basic frame: H_PIX=4, V_LINES=2, enable=1, vsync 1→0, two lines of bytes 0x12,0x34,… → 8 writes, addresses 0–7, first wdata = 0x1234, one frame_start pulse, one frame_done pulse, all flags 0.
- Mid-frame start: enable rises while vsync=0 and href is toggling → no we until vsync goes high and then low again; first write is at waddr 0.
- Long line: 6 pixels on line 0 with H_PIX=4 → writes only at addresses 0–3, line_ovf=1, line 1 starts at waddr 4.
- Odd bytes and extra lines: 7 bytes on one line → 3 writes and odd_err=1; next line's first pixel pairs correctly. A third line with V_LINES=2 → no writes for it, frame_ovf=1; flags clear at the next frame_start.
- Enable drop: enable→0 mid-frame → the rest of the frame is written, frame_done pulses, state is IDLE, and no frame_start follows.
- Reset mid-line: reset low after 3 pixels → we, waddr and the flags read 0 at once; after release, no writes until a full vsync cycle completes.
